// File: rtl/regfile_param.sv
// rtl/regfile_param.sv - parametrised N-read/1-write register file with write-first bypass and zeroing sweep
// Optional macro REGFILE_R0_ZERO_EN hardwires entry 0 to zero.
module regfile_param #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3,
  parameter int NUM_RD = 2
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic                       clear_i,
  output logic                       ready_o,
  input  logic                       write_i,
  input  logic [ADDR_W-1:0]          write_addr_i,
  input  logic [DATA_W-1:0]          write_data_i,
  input  logic [NUM_RD*ADDR_W-1:0]   rd_addr_i,
  output logic [NUM_RD*DATA_W-1:0]   rd_data_o
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] LAST = {ADDR_W{1'b1}};

`ifdef REGFILE_R0_ZERO_EN
  localparam bit R0_ZERO = 1'b1;
`else
  localparam bit R0_ZERO = 1'b0;
`endif

  typedef enum logic {INIT, RUN} state_t;

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0]  mem [DEPTH];

  logic               mem_we;
  logic [ADDR_W-1:0]  mem_waddr;
  logic [DATA_W-1:0]  mem_wdata;
  logic               wr_ok;

  // A writeback only lands in RUN, and never alongside a clear request.
  assign wr_ok = write_i && !(R0_ZERO && (write_addr_i == '0));

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mem_we    = 1'b0;
    mem_waddr = write_addr_i;
    mem_wdata = write_data_i;
    case (state_q)
      INIT: begin
        mem_we    = 1'b1;
        mem_waddr = cnt_q;
        mem_wdata = '0;
        cnt_d     = cnt_q + ADDR_W'(1);
        if (cnt_q == LAST) state_d = RUN;
      end
      RUN: begin
        if (clear_i) begin
          state_d = INIT;
          cnt_d   = '0;
        end else begin
          mem_we = wr_ok;
        end
      end
      default: begin
        state_d = INIT;
        cnt_d   = '0;
      end
    endcase
    if (reset_i) mem_we = 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Storage carries no reset so it can map onto a RAM macro.
  always_ff @(posedge clk_i) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  assign ready_o = (state_q == RUN);

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] rdat;
    assign ra = rd_addr_i[k*ADDR_W +: ADDR_W];
    always_comb begin
      rdat = '0;
      if (state_q == RUN) begin
        if (R0_ZERO && (ra == '0))
          rdat = '0;
        else if (write_i && (ra == write_addr_i))
          rdat = write_data_i;
        else
          rdat = mem[ra];
      end
    end
    assign rd_data_o[k*DATA_W +: DATA_W] = rdat;
  end

endmodule

// File: tb/tb_regfile_param.sv
// tb/tb_regfile_param.sv - directed self-checking bench for regfile_param
// Expectations for entry 0 follow REGFILE_R0_ZERO_EN when it is defined.
module tb_regfile_param;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 3;
  localparam int NUM_RD = 2;

`ifdef REGFILE_R0_ZERO_EN
  localparam logic [7:0] R0_EXP = 8'h00;
`else
  localparam logic [7:0] R0_EXP = 8'hFF;
`endif

  logic                      clk_i = 1'b0;
  logic                      reset_i;
  logic                      clear_i;
  logic                      ready_o;
  logic                      write_i;
  logic [ADDR_W-1:0]         write_addr_i;
  logic [DATA_W-1:0]         write_data_i;
  logic [NUM_RD*ADDR_W-1:0]  rd_addr_i;
  logic [NUM_RD*DATA_W-1:0]  rd_data_o;

  int total = 0;
  int bad   = 0;
  int n;

  regfile_param #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_RD(NUM_RD)) dut (
    .clk_i        (clk_i),
    .reset_i      (reset_i),
    .clear_i      (clear_i),
    .ready_o      (ready_o),
    .write_i      (write_i),
    .write_addr_i (write_addr_i),
    .write_data_i (write_data_i),
    .rd_addr_i    (rd_addr_i),
    .rd_data_o    (rd_data_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic rd(input logic [ADDR_W-1:0] a0, input logic [ADDR_W-1:0] a1);
    rd_addr_i = {a1, a0};
    #1;
  endtask

  // Counts edges until ready_o rises, bounded so a stuck sweep still ends the run.
  task automatic wait_ready(output int cycles);
    cycles = 0;
    while (!ready_o && cycles < 40) begin
      step();
      cycles++;
    end
  endtask

  initial begin
    reset_i = 1'b1; clear_i = 1'b0; write_i = 1'b0;
    write_addr_i = '0; write_data_i = '0; rd_addr_i = '0;
    step();
    reset_i = 1'b0;
    chk("ready_after_reset", ready_o, 0);
    rd(3'd6, 3'd1);
    chk("init_rd0_zero", rd_data_o[7:0], 8'h00);
    chk("init_rd1_zero", rd_data_o[15:8], 8'h00);

    // Writes during INIT must be dropped, including at the last sweep slot.
    write_i = 1'b1; write_addr_i = 3'd2; write_data_i = 8'h11;
    wait_ready(n);
    write_i = 1'b0;
    chk("init_len_after_reset", n, 8);
    for (int a = 0; a < 8; a++) begin
      rd(a[2:0], 3'(7 - a));
      chk($sformatf("swept_p0_a%0d", a), rd_data_o[7:0], 8'h00);
      chk($sformatf("swept_p1_a%0d", 7 - a), rd_data_o[15:8], 8'h00);
    end

    write_i = 1'b1; write_addr_i = 3'd3; write_data_i = 8'hA5;
    step();
    write_i = 1'b0;
    rd(3'd3, 3'd3);
    chk("wr3_p0", rd_data_o[7:0], 8'hA5);
    chk("wr3_p1", rd_data_o[15:8], 8'hA5);

    write_i = 1'b1; write_addr_i = 3'd5; write_data_i = 8'h3C;
    rd(3'd4, 3'd5);
    chk("bypass_p1", rd_data_o[15:8], 8'h3C);
    chk("bypass_p0_other", rd_data_o[7:0], 8'h00);
    step();
    write_i = 1'b0;
    rd(3'd4, 3'd5);
    chk("wr5_stored", rd_data_o[15:8], 8'h3C);

    write_i = 1'b1; write_addr_i = 3'd6; write_data_i = 8'h77;
    step();
    write_i = 1'b0;
    rd(3'd6, 3'd3);
    chk("wr6_stored", rd_data_o[7:0], 8'h77);

    // Clear with a simultaneous write: write dropped, stale data masked while sweeping.
    clear_i = 1'b1; write_i = 1'b1; write_addr_i = 3'd7; write_data_i = 8'h99;
    step();
    clear_i = 1'b0; write_i = 1'b0;
    chk("clear_ready_low", ready_o, 0);
    rd(3'd6, 3'd3);
    chk("clear_rd_masked6", rd_data_o[7:0], 8'h00);
    chk("clear_rd_masked3", rd_data_o[15:8], 8'h00);
    wait_ready(n);
    chk("clear_init_len", n, 8);
    rd(3'd6, 3'd7);
    chk("clear_a6_zero", rd_data_o[7:0], 8'h00);
    chk("clear_a7_zero", rd_data_o[15:8], 8'h00);

    // Reset on sweep cycle 4 restarts the sweep; a clear inside INIT is ignored.
    clear_i = 1'b1;
    step();
    clear_i = 1'b0;
    repeat (4) step();
    chk("mid_sweep_ready", ready_o, 0);
    reset_i = 1'b1;
    step();
    reset_i = 1'b0;
    clear_i = 1'b1;
    step();
    clear_i = 1'b0;
    wait_ready(n);
    chk("restart_init_len", n + 1, 8);

    write_i = 1'b1; write_addr_i = 3'd0; write_data_i = 8'hFF;
    rd(3'd0, 3'd1);
    chk("r0_same_cycle", rd_data_o[7:0], R0_EXP);
    step();
    write_i = 1'b0;
    rd(3'd0, 3'd0);
    chk("r0_later_p0", rd_data_o[7:0], R0_EXP);
    chk("r0_later_p1", rd_data_o[15:8], R0_EXP);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/regfile_param.md
Name: regfile_param

Overview:
- Parametrised general-purpose register file; next generation of the processor's 8x8 two-read/one-write register file.
- Generalised in data width, depth and read-port count.
- Write-through bypass on read ports.
- Hardware initialisation sequencer: every entry swept to zero after reset or on request, so storage can map to RAM without a multi-entry reset.
- Sits in the decode stage; feeds operand muxes and receives the writeback port.

Parameters:
- DATA_W, 8, bits per register
- ADDR_W, 3, address bits; DEPTH = 2**ADDR_W entries
- NUM_RD, 2, number of independent combinational read ports (1..4)

Ports:
- clk_i  input  1  single clock; all state updates on rising edge
- reset_i  input  1  synchronous, active-high reset
- clear_i  input  1  request re-initialisation of all entries to zero (honoured only in RUN)
- ready_o  output  1  high when the file is in RUN and accepting writes
- write_i  input  1  write enable
- write_addr_i  input  ADDR_W  write address
- write_data_i  input  DATA_W  write data
- rd_addr_i  input  NUM_RD*ADDR_W  packed read addresses; port k uses bits [k*ADDR_W +: ADDR_W]
- rd_data_o  output  NUM_RD*DATA_W  packed read data; port k drives bits [k*DATA_W +: DATA_W]

Behaviour:
- Clocking and reset: one clock. Reset is synchronous and active-high. reset_i sampled high at a rising edge:
  - state goes to INIT, sweep counter goes to 0, ready_o goes to 0.
  - Register contents are not reset directly; the sweep clears them.
- State machine: two states, INIT and RUN.
  - INIT: each cycle writes 0 to entry[cnt] and increments cnt.
  - When cnt == DEPTH-1 is written: next state RUN, ready_o = 1 on the following cycle, cnt returns to 0.
  - INIT lasts exactly DEPTH cycles after reset deasserts.
  - RUN: clear_i = 1 at a rising edge goes to INIT, cnt = 0, ready_o = 0. A write presented in that same cycle is dropped.
  - reset_i has priority over clear_i and write_i in every state.
  - Reset asserted mid-INIT restarts the sweep at cnt = 0.
  - clear_i in INIT is ignored; the sweep is not restarted.
- Write: in RUN with write_i = 1, entry[write_addr_i] <= write_data_i at the rising edge. In INIT, write_i is ignored.
- Read: combinational, zero-cycle latency, all ports independent. Ports may share an address.
- Bypass: in RUN, if write_i = 1 and rd_addr_k == write_addr_i, port k returns write_data_i in the same cycle (write-first). Otherwise it returns entry[rd_addr_k].
- Read during INIT: all rd_data_o ports return 0 regardless of address or stale contents.
- Widths: no arithmetic on data. Addresses are full-range; every ADDR_W value is a valid entry, so there is no out-of-range case.

Optional Feature:
- Macro: REGFILE_R0_ZERO_EN.
- Defined: entry 0 is hardwired to zero.
  - Writes to address 0 are discarded.
  - Reads of address 0 return 0, and the bypass never forwards for address 0.
  - The INIT sweep still takes DEPTH cycles.
- Undefined: entry 0 is an ordinary register.

Test Plan:
- Reset 1 cycle, then idle (DEPTH=8) -> ready_o = 0 for exactly 8 cycles, then 1; reads of all addresses return 0x00.
- RUN: write addr 3 = 0xA5; next cycle read port0 = 3, port1 = 3 -> both return 0xA5.
- RUN: write addr 5 = 0x3C with port1 addr 5 in the same cycle -> port1 = 0x3C combinationally (bypass); port0 at addr 4 unaffected.
- Write 0x11 to addr 2 during INIT -> after RUN reached, addr 2 reads 0x00.
- RUN with addr 6 = 0x77, assert clear_i for 1 cycle -> ready_o low 8 cycles, reads 0 during sweep, addr 6 = 0x00 afterwards. Reset asserted on sweep cycle 4 restarts the full 8-cycle sweep.
- REGFILE_R0_ZERO_EN defined: write addr 0 = 0xFF -> same-cycle and later reads of addr 0 return 0x00. Undefined: later reads return 0xFF.
